// File: rtl/dm_responder.sv
// Word-addressed data-memory responder for the CPU MEM stage: one load/store per
// request, completed after WAIT wait states with a one-cycle ack and a comb stall.
module dm_responder #(
  parameter int ADDR_W = 5,
  parameter int WAIT   = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              stall
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Load data is latched on the edge entering RESP, so it is valid alongside ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT == 0) begin
            state_d = S_RESP;
            if (!we) rdata_d = mem[addr];
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_CNT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          if (!we_q) rdata_d = mem[addr_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack = (state_q == S_RESP);
  end

  // Store commits on the edge leaving RESP; reset forces IDLE so a pending store is dropped.
  always_ff @(posedge Clock) begin
    if (state_q == S_RESP && we_q) mem[addr_q] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign stall = req & ~ack;
endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: WAIT=2 and WAIT=0 instances, directed table, corner
// sequences and random traffic against a word-array reference model.
module tb_dm_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [4:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        stall [2];

  int total = 0;
  int bad   = 0;
  int waits [2] = '{2, 0};

  logic [31:0] mem_m [2][32];
  logic [31:0] rd_m  [2];

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(5), .WAIT(2)) u0 (
    .Clock(clk), .Resetn(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .stall(stall[0]));

  dm_responder #(.ADDR_W(5), .WAIT(0)) u1 (
    .Clock(clk), .Resetn(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .stall(stall[1]));

  typedef struct {
    int          d;
    bit          w;
    logic [4:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
    bit          b2b;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entry/exit point: #1 after a posedge, DUT idle. Exits in the IDLE cycle after RESP.
  task automatic access(input int d, input bit w, input logic [4:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit drop);
    int wt = waits[d];
    bit exp_ack;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    for (int n = 0; n <= wt + 1; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (drop && n == 1) req[d] = 1'b0;
      end
      @(negedge clk);
      exp_ack = (n == wt + 1);
      chk($sformatf("ack d%0d n%0d", d, n), ack[d], exp_ack);
      chk($sformatf("stall d%0d n%0d", d, n), stall[d], req[d] & ~exp_ack);
      if (exp_ack) chk($sformatf("rdata d%0d a%0d", d, a), rdata[d], exp_rd);
    end
    if (w) mem_m[d][a] = wd;
    else   rd_m[d] = mem_m[d][a];
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("idle ack d%0d", d), ack[d], 1'b0);
        chk($sformatf("idle stall d%0d", d), stall[d], 1'b0);
        chk($sformatf("idle rdata d%0d", d), rdata[d], rd_m[d]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; rd_m[d] = '0;
    end
    tbl[0] = '{0, 1'b1, 5'd3,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{0, 1'b0, 5'd3,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{0, 1'b1, 5'd7,  32'h12345678, 32'hDEADBEEF, 1'b1};
    tbl[3] = '{0, 1'b0, 5'd7,  32'h0,        32'h12345678, 1'b1};
    tbl[4] = '{1, 1'b1, 5'd0,  32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[5] = '{1, 1'b0, 5'd0,  32'h0,        32'hA5A5A5A5, 1'b0};
    tbl[6] = '{1, 1'b0, 5'd0,  32'h0,        32'hA5A5A5A5, 1'b1};
    tbl[7] = '{0, 1'b1, 5'd9,  32'h11111111, 32'h12345678, 1'b0};
    tbl[8] = '{1, 1'b1, 5'd31, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0};
    tbl[9] = '{1, 1'b0, 5'd31, 32'h0,        32'hFFFFFFFF, 1'b1};

    // reset state, stall follows req even in reset
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst ack", ack[d], 1'b0);
      chk("rst rdata", rdata[d], 32'h0);
      req[d] = 1'b1; #1;
      chk("rst stall=req 1", stall[d], 1'b1);
      req[d] = 1'b0; #1;
      chk("rst stall=req 0", stall[d], 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (!tbl[i].b2b) idle(1);
      access(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].exp, 1'b0);
    end

    // flush: store survives req being dropped in WAIT
    idle(1);
    access(0, 1'b1, 5'd5, 32'hCAFEF00D, rd_m[0], 1'b1);
    idle(1);
    access(0, 1'b0, 5'd5, 32'h0, 32'hCAFEF00D, 1'b0);

    // async reset in WAIT on a store: store discarded
    idle(1);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd9; wdata[0] = 32'h22222222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst_n = 1'b0; #1;
    chk("async rst ack", ack[0], 1'b0);
    chk("async rst rdata d0", rdata[0], 32'h0);
    chk("async rst rdata d1", rdata[1], 32'h0);
    rd_m[0] = '0; rd_m[1] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b0, 5'd9, 32'h0, 32'h11111111, 1'b0);

    idle(20);

    // preload every word on both instances so random loads are defined
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++)
        access(d, 1'b1, 5'(a), $urandom, rd_m[d], 1'b0);

    for (int i = 0; i < 150; i++) begin
      int          d  = $urandom_range(0, 1);
      bit          w  = 1'($urandom_range(0, 1));
      logic [4:0]  a  = 5'($urandom_range(0, 31));
      logic [31:0] wd = $urandom;
      bit          dr = ($urandom_range(0, 3) == 0);
      idle($urandom_range(0, 2));
      access(d, w, a, wd, w ? rd_m[d] : mem_m[d][a], dr);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
# dm_responder

Word-addressed data-memory responder for the pipelined CPU's MEM stage. It accepts one load or store per request and completes it after a fixed, parameterised number of wait states. It returns an `ack` pulse and drives a combinational `stall` so the CPU pipeline freezes until the access completes. It is the memory-side end of the CPU's data-access interface and replaces the zero-latency data memory when wait states are modelled.

## Interface
- `ADDR_W`, default 5: word-address width; depth is 2^ADDR_W 32-bit words.
- `WAIT`, default 2: wait states per access; legal range 0..15.

- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request from the MEM stage; held high until `ack`.
- `we`  in  1  1 = store, 0 = load; valid with `req`.
- `addr`  in  ADDR_W  word address; valid with `req`.
- `wdata`  in  32  store data; valid with `req`.
- `rdata`  out  32  load data; valid from the `ack` cycle until the next load completes.
- `ack`  out  1  one-cycle completion pulse; registered, decoded from state RESP.
- `stall`  out  1  combinational `req & ~ack`; the CPU freezes IF/ID/EXE/MEM while this is high.

## Operation
- States: IDLE, WAIT, RESP. Wait counter `cnt` is 4 bits. Captured-request registers: `we_q`, `addr_q`, `wdata_q`.
- **IDLE:** on a rising edge with `req`=1, capture `we`, `addr` and `wdata`.
  - If `WAIT`=0, go to RESP.
  - Otherwise go to WAIT and set `cnt`=`WAIT`.
  - If `req`=0, stay in IDLE.
- **WAIT:** if `cnt`=1, go to RESP; otherwise decrement `cnt`. `req`, `addr`, `we` and `wdata` are ignored; the captured values are used.
- **Entry into RESP with `we_q`=0:** `rdata` <= `mem[addr_q]` on the same edge. Stores leave `rdata` unchanged.
- **RESP:** `ack`=1 for exactly one cycle.
  - On the edge leaving RESP, if `we_q`=1, `mem[addr_q]` <= `wdata_q`.
  - Next state is always IDLE.
- **Request withdrawn:** if `req` drops during WAIT or RESP (pipeline flush), the access still completes. `ack` still pulses and a pending store is still written.
- **Reset (async, `Resetn`=0):**
  - State goes to IDLE; `cnt`, `ack` and `rdata` go to 0; captured registers go to 0.
  - A pending store is discarded, not written.
  - Memory array contents are not reset.
- **Reset values of outputs:** `ack`=0, `rdata`=0. `stall` equals `req`.

## Timing
- Request sampled at edge k: `ack` is high during the cycle after edge k+`WAIT`. Latency is `WAIT`+1 cycles.
- Load data is valid in the same cycle as `ack`.
- A store is visible to any load sampled after the RESP cycle.
- There is always one IDLE cycle after RESP. A back-to-back request is sampled at the edge ending that IDLE cycle. Throughput is one access per `WAIT`+2 cycles.
- `stall` is high from the cycle `req` rises through the last cycle before `ack`, and low in the `ack` cycle. This includes the IDLE cycle of a back-to-back request.
- Read-after-write to the same address, back-to-back: the load returns the new data.
- `WAIT`=0: RESP follows IDLE directly and `cnt` is unused.

## Test plan
- **Load, `WAIT`=2:** preload `mem[3]`=0xDEADBEEF; assert `req`=1, `we`=0, `addr`=3 at edge 0.
  - `stall`=1 for cycles 0–2.
  - `ack`=1 and `rdata`=0xDEADBEEF in the cycle after edge 2.
  - `ack`=0 in the following cycle.
- **Store then load, same address, back-to-back:**
  - Store `wdata`=0x12345678 to `addr`=7, then load `addr`=7.
  - The load's `ack` cycle shows `rdata`=0x12345678.
  - The store's `ack` leaves `rdata` unchanged.
- **`WAIT`=0 build:** a load of `addr`=0 (preloaded 0xA5A5A5A5) sampled at edge 0 gives `ack`=1 and `rdata`=0xA5A5A5A5 after edge 0. A second load completes 2 cycles later.
- **Flush:** assert a store (`addr`=5, data 0xCAFEF00D), then drop `req` one cycle later in WAIT.
  - `ack` still pulses at the nominal cycle.
  - A subsequent load of 5 returns 0xCAFEF00D.
- **Reset mid-operation:** pull `Resetn` low while in WAIT on a store (`addr`=9, old value 0x11111111, new 0x22222222).
  - `ack`=0 and `rdata`=0 immediately (asynchronous).
  - After release, a load of 9 returns 0x11111111.
- **Idle check:** with `req`=0 for 20 cycles, `ack` and `stall` stay 0 and `rdata` holds its last value.
